// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RISC-V control FSM with memory-ready timeout and illegal/timeout traps.
// Defining RV_JAL_EN adds the JAL state (opcode 1101111); otherwise that opcode traps as illegal.
module multicycle_control #(
    parameter int MAX_WAIT          = 16,
    parameter bit TRAP_VEC_EN_STATE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal,
    output logic       mem_timeout
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd15
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] wait_cnt;
    logic          is_store, mem_state, timeout_hit;

    assign state     = cur;
    assign mem_state = (cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR);
    // The cycle in which the count would reach MAX_WAIT is the last one allowed; ready then still wins.
    assign timeout_hit = (MAX_WAIT != 0) && mem_state && !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= FETCH;
            wait_cnt    <= '0;
            is_store    <= 1'b0;
            illegal     <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready && wait_cnt != CW'(MAX_WAIT))
                wait_cnt <= wait_cnt + CW'(1);
            if (cur == DECODE)
                is_store <= opcode[5];
            if (cur == DECODE && nxt == TRAP)
                illegal <= 1'b1;
            if (timeout_hit)
                mem_timeout <= 1'b1;
        end
    end

    always_comb begin
        nxt        = cur;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                nxt       = mem_ready ? DECODE : timeout_hit ? TRAP : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    7'b0110011:             nxt = EXEC_R;
                    7'b0010011:             nxt = EXEC_I;
                    7'b0000011, 7'b0100011: nxt = MEM_ADDR;
                    7'b1100011:             nxt = BRANCH;
`ifdef RV_JAL_EN
                    7'b1101111:             nxt = JAL;
`endif
                    default:                nxt = TRAP;
                endcase
            end
            EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                nxt       = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
                nxt       = ALU_WB;
            end
            MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                nxt       = is_store ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                nxt      = mem_ready ? MEM_WB : timeout_hit ? TRAP : MEM_RD;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt        = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                nxt       = mem_ready ? FETCH : timeout_hit ? TRAP : MEM_WR;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                nxt       = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_src    = 2'b01;
                nxt       = FETCH;
            end
`ifdef RV_JAL_EN
            JAL: begin
                reg_write = 1'b1;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                nxt       = FETCH;
            end
`endif
            TRAP:    nxt = TRAP_VEC_EN_STATE ? TRAP : FETCH;
            default: nxt = TRAP;
        endcase
        // Reset kills every strobe at once so no write can complete while it is held.
        if (!rst_n)
            {pc_write, branch, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_src} = '0;
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction streams checked against a per-instruction cycle-sequence model.
module tb_multicycle_control;
    localparam int MW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, branch, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src;
    logic [3:0] state;
    logic       illegal, mem_timeout;
    logic [15:0] ctrl;

    multicycle_control #(.MAX_WAIT(MW), .TRAP_VEC_EN_STATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .illegal(illegal), .mem_timeout(mem_timeout)
    );

    assign ctrl = {pc_write, branch, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, pc_src};

    always #5 clk = ~clk;

    typedef struct {
        int         st;
        logic       rdy;
        logic [6:0] op;
        logic       ill;
        logic       to;
    } step_t;

    step_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  ill_m = 1'b0;
    logic  to_m = 1'b0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom_range(0, 127));
    endfunction

    // Control word each state must show, straight from the per-state output table.
    function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
        logic pw, br, irw, iod, mr, mwr, rw, m2r;
        logic [1:0] a, b, op, ps;
        {pw, br, irw, iod, mr, mwr, rw, m2r} = '0;
        {a, b, op, ps} = '0;
        case (st)
            0:  begin mr = 1; b = 2'b01; pw = rdy; irw = rdy; end
            1:  begin a = 2'b10; b = 2'b10; end
            2:  begin a = 2'b01; op = 2'b10; end
            3:  begin a = 2'b01; b = 2'b10; op = 2'b10; end
            4:  begin a = 2'b01; b = 2'b10; end
            5:  begin mr = 1; iod = 1; end
            6:  begin rw = 1; m2r = 1; end
            7:  begin mwr = 1; iod = 1; end
            8:  rw = 1;
            9:  begin a = 2'b01; op = 2'b01; br = 1; ps = 2'b01; end
            10: begin rw = 1; a = 2'b10; b = 2'b01; pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, br, irw, iod, mr, mwr, rw, m2r, a, b, op, ps};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int st, input logic rdy, input logic [6:0] op);
        step_t s;
        s.st = st; s.rdy = rdy; s.op = op; s.ill = ill_m; s.to = to_m;
        q.push_back(s);
    endtask

    task automatic trap_tail();
        repeat (4) push(15, rb(), ro());
    endtask

    // A memory state waits `waits` not-ready cycles; reaching MW of them traps instead.
    task automatic mem_phase(input int st, input int waits, output bit trapped);
        trapped = 0;
        for (int i = 0; i < waits && i < MW; i++) push(st, 1'b0, ro());
        if (waits >= MW) begin
            to_m = 1'b1;
            trapped = 1;
            trap_tail();
        end else
            push(st, 1'b1, ro());
    endtask

    task automatic build(input logic [6:0] op, input int fw, input int mw);
        bit t;
        mem_phase(0, fw, t);
        if (t) return;
        push(1, rb(), op);
        case (op)
            7'b0110011: begin push(2, rb(), ro()); push(8, rb(), ro()); end
            7'b0010011: begin push(3, rb(), ro()); push(8, rb(), ro()); end
            7'b0000011: begin push(4, rb(), ro()); mem_phase(5, mw, t); if (!t) push(6, rb(), ro()); end
            7'b0100011: begin push(4, rb(), ro()); mem_phase(7, mw, t); end
            7'b1100011: push(9, rb(), ro());
`ifdef RV_JAL_EN
            7'b1101111: push(10, rb(), ro());
`endif
            default: begin ill_m = 1'b1; trap_tail(); end
        endcase
    endtask

    task automatic run_step(input step_t s);
        opcode = s.op;
        mem_ready = s.rdy;
        @(negedge clk);
        check($sformatf("state exp_st=%0d", s.st), 32'(state), 32'(s.st));
        check($sformatf("ctrl st=%0d rdy=%0b", s.st, s.rdy), 32'(ctrl), 32'(exp_ctrl(s.st, s.rdy)));
        check($sformatf("flags st=%0d", s.st), 32'({illegal, mem_timeout}), 32'({s.ill, s.to}));
        @(posedge clk);
        #1;
    endtask

    task automatic run_all();
        while (q.size() > 0) run_step(q.pop_front());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #2;
        check("reset state", 32'(state), 32'd0);
        check("reset strobes", 32'(ctrl), 32'd0);
        check("reset flags", 32'({illegal, mem_timeout}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ill_m = 1'b0;
        to_m = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops[5];
        logic [6:0] bad;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
        opcode = 7'd0;
        mem_ready = 1'b0;
        #1;
        do_reset();

        build(7'b0110011, 0, 0); run_all();
        build(7'b0000011, 0, 3); run_all();
        build(7'b1100011, 0, 0); run_all();
        build(7'b0100011, 1, 2); run_all();
        build(7'b0010011, 3, 0); run_all();

        for (int i = 0; i < 40; i++) begin
            build(ops[$urandom_range(0, 4)], $urandom_range(0, 3), $urandom_range(0, 3));
            run_all();
        end

        build(7'b0110011, MW, 0); run_all(); do_reset();
        build(7'b0000011, 0, MW + $urandom_range(0, 2)); run_all(); do_reset();
        build(7'b0100011, 1, MW); run_all(); do_reset();
        build(7'b0000000, 0, 0); run_all(); do_reset();
        do bad = ro();
        while (bad inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111});
        build(bad, 2, 0); run_all(); do_reset();
        build(7'b1101111, 0, 0); run_all(); do_reset();
        build(7'b0110011, 0, 0); run_all();

        build(7'b0100011, 0, 3);
        for (int i = 0; i < 4; i++) run_step(q.pop_front());
        q.delete();
        do_reset();
        build(7'b0000011, 1, 1); run_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RISC-V core; the next generation of the single-cycle decoder. It is a Moore/Mealy FSM that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one memory port and one ALU. It handles variable-latency memory through a ready handshake with a configurable timeout, and traps on illegal opcodes or memory hangs.

## Interface
- MAX_WAIT, 16: memory wait-cycle limit per access; 0 disables the timeout.
- TRAP_VEC_EN_STATE, 1: 1 makes TRAP sticky until reset; 0 returns to FETCH one cycle after entering TRAP.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  instruction[6:0] from IR; sampled only in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- branch  out  1  PC load if datapath zero flag is set
- ir_write  out  1  IR load
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write
- mem_to_reg  out  1  write-back select: 1 = MDR, 0 = ALUOut
- alu_src_a  out  2  00 = PC, 01 = rs1, 10 = old PC
- alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = imm
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct decode
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state encoding, for debug
- illegal  out  1  unsupported opcode trapped; sticky
- mem_timeout  out  1  memory wait exceeded MAX_WAIT; sticky

## Operation
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, ALU_WB 8, BRANCH 9, JAL 10, TRAP 15.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - On mem_ready, asserts ir_write and pc_write in that same cycle (Mealy) and moves to DECODE. Otherwise it holds.
- DECODE:
  - Drives alu_src_a=10, alu_src_b=10 to precompute the branch target.
  - Dispatches on opcode: 0110011→EXEC_R; 0010011→EXEC_I; 0000011/0100011→MEM_ADDR; 1100011→BRANCH; 1101111→JAL (macro only). Anything else goes to TRAP and sets illegal.
- EXEC_R: alu_src_a=01, alu_src_b=00, alu_op=10; next state ALU_WB.
- EXEC_I: alu_src_a=01, alu_src_b=10, alu_op=10; next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0; next state FETCH.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. The load/store decision uses opcode latched at DECODE: load→MEM_RD, store→MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; moves to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1; next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1; moves to FETCH on mem_ready.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, branch=1, pc_src=01; next state FETCH.
- Wait counter:
  - Clears on entry to any memory state (FETCH, MEM_RD, MEM_WR) and increments each cycle mem_ready is low.
  - When it reaches MAX_WAIT with mem_ready low (and MAX_WAIT≠0), the FSM goes to TRAP and sets mem_timeout.
  - mem_ready in the same cycle as the limit wins: no trap.
  - Counter width is $clog2(MAX_WAIT+1), saturating.
- TRAP: all strobes are 0. Exit follows TRAP_VEC_EN_STATE. illegal and mem_timeout clear only on reset.
- All outputs not listed for a state are 0.

## Timing
- Reset (asynchronous assertion, synchronous release): state=FETCH, wait counter=0, illegal=0, mem_timeout=0. All strobes are 0 except the FETCH Moore outputs, which appear from the first cycle.
- Cycle counts with zero-wait memory (mem_ready=1 on the first cycle):
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - jal: 3 cycles
- Each memory wait cycle adds one cycle.
- State register and sticky flags update on the rising clk edge. Strobe outputs are combinational from state, plus mem_ready where noted.
- rst_n asserted mid-instruction drops all strobes immediately; no partial write completes after assertion.

## Configuration
- RV_JAL_EN defined:
  - Opcode 1101111 decodes to JAL.
  - JAL drives reg_write=1, mem_to_reg=0, alu_src_a=10, alu_src_b=01 (rd=PC+4), pc_write=1, pc_src=10; next state FETCH.
- RV_JAL_EN undefined: state 10 is unreachable and 1101111 traps as illegal.

## Test plan
- Reset, then add (0110011), mem_ready always 1 → states 0,1,2,8,0; reg_write high exactly in cycle 4; pc_write and ir_write high in cycle 1.
- lw (0000011) with mem_ready low for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles; mem_to_reg=1 and reg_write=1 in the following cycle; total 8 cycles.
- MAX_WAIT=4, mem_ready held low in FETCH → TRAP after 4 wait cycles with mem_timeout=1. A variant with mem_ready rising in the 4th cycle reaches DECODE with no trap.
- Opcode 0000000 at DECODE → TRAP next cycle, illegal=1, all strobes 0. It stays there (TRAP_VEC_EN_STATE=1) until rst_n pulses low, after which state=0 and illegal=0.
- beq (1100011) → 3 cycles, branch=1 with alu_op=01 and pc_src=01 only in BRANCH.
- jal (1101111): with RV_JAL_EN → state 10, reg_write=1, pc_src=10; without RV_JAL_EN → TRAP with illegal=1.
